// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - hold/flush/redirect control for the 5-stage pipeline registers
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int HOLD_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_req_i,
    input  logic [31:0] jump_addr_i,
    input  logic        load_use_i,
    input  logic        div_busy_i,
    input  logic        mem_wait_i,
    output logic        pc_hold_o,
    output logic        if_id_hold_o,
    output logic        if_id_flush_o,
    output logic        id_ex_hold_o,
    output logic        id_ex_flush_o,
    output logic        ex_mem_hold_o,
    output logic        jump_o,
    output logic [31:0] jump_addr_o,
    output logic        hold_err_o
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_PEND  = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
    localparam bit         MULTI      = (FLUSH_CYCLES > 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] pend_q, pend_d;
    logic [15:0] wd_q;
    logic        err_q;

    logic        stall;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        flush;
    logic        lu_act;
    logic        pc_hold;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pend_d        = pend_q;
        redirect      = 1'b0;
        redirect_addr = 32'd0;
        flush         = 1'b0;
        stall         = mem_wait_i | div_busy_i;
        case (state_q)
            S_RUN: begin
                if (jump_req_i) begin
                    if (!stall) begin
                        redirect      = 1'b1;
                        redirect_addr = jump_addr_i;
                        flush         = 1'b1;
                        if (MULTI) begin
                            state_d = S_FLUSH;
                            cnt_d   = FLUSH_INIT;
                        end
                    end else begin
                        // Park the target; EX stays frozen until the stall clears.
                        pend_d  = jump_addr_i;
                        state_d = S_PEND;
                    end
                end
            end
            S_PEND: begin
                if (!stall) begin
                    redirect      = 1'b1;
                    redirect_addr = pend_q;
                    flush         = 1'b1;
                    state_d       = MULTI ? S_FLUSH : S_RUN;
                    cnt_d         = FLUSH_INIT;
                end
            end
            S_FLUSH: begin
                flush = 1'b1;
                if (!stall) begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        state_d = S_RUN;
                    end
                end
            end
            default: state_d = S_RUN;
        endcase
        lu_act  = load_use_i & ~stall & ~redirect;
        pc_hold = stall | lu_act;
    end

    // Flushes take precedence over holds of the same register.
    assign pc_hold_o     = ~rst & pc_hold;
    assign if_id_flush_o = ~rst & flush;
    assign if_id_hold_o  = ~rst & pc_hold & ~flush;
    assign id_ex_flush_o = ~rst & (flush | lu_act);
    assign id_ex_hold_o  = ~rst & stall & ~flush;
    assign ex_mem_hold_o = ~rst & mem_wait_i;
    assign jump_o        = ~rst & redirect;
    assign jump_addr_o   = rst ? 32'd0 : redirect_addr;
    assign hold_err_o    = ~rst & err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            cnt_q   <= 3'd0;
            pend_q  <= 32'd0;
            wd_q    <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            if (pc_hold) begin
                if (!(&wd_q)) begin
                    wd_q <= wd_q + 16'd1;
                end
                if (({1'b0, wd_q} + 17'd1) >= 17'(HOLD_TIMEOUT)) begin
                    err_q <= 1'b1;
                end
            end else begin
                wd_q <= 16'd0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed and randomized checks of pipe_ctrl against a behavioural model
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        jump_req;
    logic [31:0] jump_addr;
    logic        load_use;
    logic        div_busy;
    logic        mem_wait;

    // ctrl = {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_hold, jump, hold_err}
    wire [7:0]  ctrl_a, ctrl_b;
    wire [31:0] addr_a, addr_b;

    pipe_ctrl #(.FLUSH_CYCLES(1), .HOLD_TIMEOUT(4)) u_a (
        .clk(clk), .rst(rst), .jump_req_i(jump_req), .jump_addr_i(jump_addr),
        .load_use_i(load_use), .div_busy_i(div_busy), .mem_wait_i(mem_wait),
        .pc_hold_o(ctrl_a[7]), .if_id_hold_o(ctrl_a[6]), .if_id_flush_o(ctrl_a[5]),
        .id_ex_hold_o(ctrl_a[4]), .id_ex_flush_o(ctrl_a[3]), .ex_mem_hold_o(ctrl_a[2]),
        .jump_o(ctrl_a[1]), .jump_addr_o(addr_a), .hold_err_o(ctrl_a[0])
    );

    pipe_ctrl #(.FLUSH_CYCLES(3), .HOLD_TIMEOUT(8)) u_b (
        .clk(clk), .rst(rst), .jump_req_i(jump_req), .jump_addr_i(jump_addr),
        .load_use_i(load_use), .div_busy_i(div_busy), .mem_wait_i(mem_wait),
        .pc_hold_o(ctrl_b[7]), .if_id_hold_o(ctrl_b[6]), .if_id_flush_o(ctrl_b[5]),
        .id_ex_hold_o(ctrl_b[4]), .id_ex_flush_o(ctrl_b[3]), .ex_mem_hold_o(ctrl_b[2]),
        .jump_o(ctrl_b[1]), .jump_addr_o(addr_b), .hold_err_o(ctrl_b[0])
    );

    int checks   = 0;
    int failures = 0;

    int          fc[2];
    int          tmo[2];
    int          flush_left[2];
    int          run[2];
    bit          pend[2];
    bit          err[2];
    logic [31:0] pend_addr[2];
    logic [7:0]  exp_ctrl[2];
    logic [31:0] exp_addr[2];
    bit          exp_redir[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int k);
        flush_left[k] = 0;
        run[k]        = 0;
        pend[k]       = 0;
        err[k]        = 0;
        pend_addr[k]  = 32'd0;
    endtask

    task automatic eval(input int k);
        bit stall, fl, redir, lu, ph;
        logic [31:0] a;
        stall = mem_wait || div_busy;
        redir = 0;
        a     = 32'd0;
        if (rst) begin
            exp_ctrl[k]  = 8'd0;
            exp_addr[k]  = 32'd0;
            exp_redir[k] = 0;
            return;
        end
        if (flush_left[k] == 0) begin
            if (pend[k]) begin
                if (!stall) begin redir = 1; a = pend_addr[k]; end
            end else if (jump_req && !stall) begin
                redir = 1; a = jump_addr;
            end
        end
        fl = redir || (flush_left[k] > 0);
        lu = load_use && !stall && !redir;
        ph = stall || lu;
        exp_ctrl[k]  = {ph, ph && !fl, fl, stall && !fl, fl || lu, mem_wait, redir, err[k]};
        exp_addr[k]  = a;
        exp_redir[k] = redir;
    endtask

    task automatic update(input int k);
        bit stall;
        stall = mem_wait || div_busy;
        if (rst) begin
            model_reset(k);
            return;
        end
        if (exp_redir[k]) begin
            flush_left[k] = fc[k] - 1;
            pend[k]       = 0;
        end else if (flush_left[k] > 0) begin
            if (!stall) flush_left[k]--;
        end else if (!pend[k] && jump_req && stall) begin
            pend[k]      = 1;
            pend_addr[k] = jump_addr;
        end
        if (exp_ctrl[k][7]) begin
            if (run[k] < 65535) run[k]++;
            if (run[k] >= tmo[k]) err[k] = 1;
        end else begin
            run[k] = 0;
        end
    endtask

    task automatic drive(input logic r, input logic jr, input logic [31:0] ja,
                         input logic lu, input logic db, input logic mw);
        rst       = r;
        jump_req  = jr;
        jump_addr = ja;
        load_use  = lu;
        div_busy  = db;
        mem_wait  = mw;
    endtask

    task automatic sample();
        @(negedge clk);
        eval(0);
        eval(1);
        chk("ctrl_a", {24'd0, ctrl_a}, {24'd0, exp_ctrl[0]});
        chk("addr_a", addr_a, exp_addr[0]);
        chk("ctrl_b", {24'd0, ctrl_b}, {24'd0, exp_ctrl[1]});
        chk("addr_b", addr_b, exp_addr[1]);
    endtask

    task automatic advance();
        @(posedge clk);
        update(0);
        update(1);
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    initial begin
        fc[0] = 1; fc[1] = 3;
        tmo[0] = 4; tmo[1] = 8;
        model_reset(0);
        model_reset(1);

        // reset with every input high
        drive(1, 1, 32'hFFFF_FFFF, 1, 1, 1);
        step();
        sample();
        chk("reset_ctrl", {24'd0, ctrl_a}, 32'd0);
        chk("reset_addr", addr_b, 32'd0);
        advance();
        drive(0, 0, 32'd0, 0, 0, 0);
        step();
        sample();
        chk("idle_ctrl", {24'd0, ctrl_b}, 32'd0);
        advance();

        // plain jump
        drive(0, 1, 32'h0000_0100, 0, 0, 0);
        sample();
        chk("plain_ctrl", {24'd0, ctrl_a}, 32'h2A);
        chk("plain_addr", addr_a, 32'h100);
        advance();
        drive(0, 0, 32'd0, 0, 0, 0);
        sample();
        chk("plain_after", {24'd0, ctrl_a}, 32'd0);
        chk("multi_flush2", {24'd0, ctrl_b}, 32'h28);
        advance();
        repeat (2) step();

        // multi-cycle flush with a wait state on the second cycle
        drive(0, 1, 32'h0000_0180, 0, 0, 0);
        step();
        drive(0, 0, 32'd0, 0, 0, 1);
        sample();
        chk("flush_wait", {24'd0, ctrl_b}, 32'hAC);
        advance();
        drive(0, 0, 32'd0, 0, 0, 0);
        repeat (2) step();
        sample();
        chk("flush_done", {24'd0, ctrl_b}, 32'd0);
        advance();

        // parked jump behind a busy divider
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 32'h0000_0200, 0, 1, 0);
            sample();
            chk("park_jump", {31'd0, ctrl_b[1]}, 32'd0);
            chk("park_hold", {29'd0, ctrl_b[7:6], ctrl_b[4]}, 32'd7);
            advance();
        end
        drive(0, 1, 32'h0000_0300, 0, 0, 0);
        sample();
        chk("park_release", addr_b, 32'h200);
        chk("park_flush", {30'd0, ctrl_b[5], ctrl_b[3]}, 32'd3);
        advance();
        drive(0, 0, 32'd0, 0, 0, 0);
        repeat (3) step();

        // load-use against redirect priority
        drive(1, 0, 32'd0, 0, 0, 0);
        step();
        drive(0, 1, 32'h0000_0400, 1, 0, 0);
        sample();
        chk("prio_jump", {24'd0, ctrl_a}, 32'h2A);
        advance();
        drive(0, 0, 32'd0, 0, 0, 0);
        repeat (3) step();
        drive(0, 0, 32'd0, 1, 0, 0);
        sample();
        chk("load_use", {24'd0, ctrl_a}, 32'hC8);
        advance();

        // watchdog threshold
        drive(1, 0, 32'd0, 0, 0, 0);
        step();
        drive(0, 0, 32'd0, 0, 0, 1);
        repeat (3) step();
        drive(0, 0, 32'd0, 0, 0, 0);
        sample();
        chk("wd_below", {31'd0, ctrl_a[0]}, 32'd0);
        advance();
        drive(0, 0, 32'd0, 0, 0, 1);
        repeat (4) step();
        drive(0, 0, 32'd0, 0, 0, 0);
        sample();
        chk("wd_set", {31'd0, ctrl_a[0]}, 32'd1);
        advance();
        sample();
        chk("wd_sticky", {31'd0, ctrl_a[0]}, 32'd1);
        advance();
        drive(1, 0, 32'd0, 0, 0, 0);
        step();
        drive(0, 0, 32'd0, 0, 0, 0);
        sample();
        chk("wd_cleared", {31'd0, ctrl_a[0]}, 32'd0);
        advance();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(99) == 0), ($urandom_range(3) == 0), $urandom,
                  ($urandom_range(4) == 0), ($urandom_range(5) == 0), ($urandom_range(5) == 0));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline control unit for the 5-stage core. It owns the hold and flush controls of the PC register and of the if_id, id_ex and ex_mem pipeline registers. It arbitrates between EX branch/jump redirects, the ID load-use hazard, multi-cycle EX units (divider) and bus wait states. It sequences multi-cycle flush windows and parks redirects that arrive while the pipe is held.

Parameters:
FLUSH_CYCLES, 1, number of consecutive cycles if_id/id_ex are flushed per redirect (legal 1..4)
HOLD_TIMEOUT, 64, consecutive pc_hold_o cycles after which hold_err_o sets (legal 2..65535)

Ports:
clk  input  1  core clock
rst  input  1  synchronous reset, active-high
jump_req_i  input  1  EX requests redirect (branch taken / jal / jalr)
jump_addr_i  input  32  redirect target, valid with jump_req_i
load_use_i  input  1  ID detected load-use hazard
div_busy_i  input  1  EX multi-cycle unit busy
mem_wait_i  input  1  MEM stage bus not ready
pc_hold_o  output  1  PC keeps value
if_id_hold_o  output  1  if_id keeps contents
if_id_flush_o  output  1  if_id loads NOP
id_ex_hold_o  output  1  id_ex keeps contents
id_ex_flush_o  output  1  id_ex loads bubble
ex_mem_hold_o  output  1  ex_mem keeps contents
jump_o  output  1  PC loads jump_addr_o this cycle
jump_addr_o  output  32  redirect target to PC
hold_err_o  output  1  sticky watchdog error

Behaviour:
- Reset (rst=1 at posedge): state RUN, pending flag 0, flush counter 0, watchdog 0, hold_err_o 0. While in reset all outputs are 0 and jump_addr_o is 0. Reset mid-FLUSH or mid-PEND drops the sequence.
- Hold levels, decoded combinationally; higher level wins:
  - mem_wait_i: pc, if_id, id_ex and ex_mem hold.
  - else div_busy_i: pc, if_id and id_ex hold.
  - else load_use_i (only if no redirect this cycle): pc and if_id hold, id_ex_flush_o=1.
- A flush output overrides the hold of the same register. The register must never see hold and flush both active.
- States: RUN, FLUSH, PEND.
- RUN, jump_req_i=1, no mem_wait/div_busy:
  - Same cycle: jump_o=1, jump_addr_o=jump_addr_i, if_id_flush_o=1, id_ex_flush_o=1. load_use_i is ignored.
  - If FLUSH_CYCLES>1: go to FLUSH with counter=FLUSH_CYCLES-1.
- RUN, jump_req_i=1 with mem_wait_i or div_busy_i: capture jump_addr_i into the pending register and go to PEND. jump_o stays 0.
- PEND:
  - Holds follow their levels. Further jump_req_i is ignored, because EX is frozen and represents the same redirect.
  - First cycle with mem_wait_i=0 and div_busy_i=0: jump_o=1, jump_addr_o=pending register, both flushes asserted.
  - Next state is FLUSH (if FLUSH_CYCLES>1) or RUN.
- FLUSH:
  - if_id_flush_o=1 and id_ex_flush_o=1 every cycle; jump_o=0.
  - Counter decrements only on cycles without mem_wait_i/div_busy_i. Holds still apply to pc and ex_mem.
  - Go to RUN when the counter reaches 0.
  - A new jump_req_i in FLUSH is ignored; that instruction is being squashed.
- jump_addr_o is 0 whenever jump_o=0.
- Watchdog:
  - 16-bit counter increments each cycle pc_hold_o=1 and clears when pc_hold_o=0; it saturates.
  - hold_err_o sets on the cycle the count reaches HOLD_TIMEOUT and stays set until rst. hold_err_o has no effect on the pipeline.
- Output latency: holds, flushes and jump_o are combinational from the inputs and current state. State, pending address, counters and hold_err_o are registered.

Test Plan:
- Reset: assert rst 2 cycles with all inputs 1 -> all outputs 0. After release with inputs 0 -> all outputs 0, state RUN.
- Plain jump, FLUSH_CYCLES=1: jump_req_i=1, jump_addr_i=0x0000_0100 for 1 cycle -> same cycle jump_o=1, jump_addr_o=0x100, if_id_flush_o=id_ex_flush_o=1. Next cycle all 0.
- Multi-flush, FLUSH_CYCLES=3, with mem_wait_i=1 on the 2nd cycle -> flushes asserted on 4 cycles (the counter pauses once), ex_mem_hold_o=1 on the wait cycle, jump_o high on cycle 1 only.
- Parked jump: div_busy_i=1 for 5 cycles with jump_req_i=1, addr 0x0000_0200 -> pc/if_id/id_ex hold and jump_o=0 for 5 cycles. On cycle 6 jump_o=1 with addr 0x200 plus both flushes.
- Priority: load_use_i=1 with jump_req_i=1 -> redirect with both flushes, no pc_hold_o. load_use_i alone -> pc_hold_o=if_id_hold_o=1, id_ex_flush_o=1, id_ex_hold_o=0.
- Watchdog, HOLD_TIMEOUT=4: mem_wait_i=1 for 3 cycles then 0 -> no error. mem_wait_i=1 for 4 cycles -> hold_err_o=1 after the 4th and still 1 after mem_wait_i drops, until rst.
